// File: rtl/boreal_wload_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : boreal_wload_pkg
//  Purpose  : Shared definitions for the boreal weight loader.
//             - Parser/commit state encoding.
//             - Error cause codes.
//             - Default geometry and framing constants.
//  Revision : 1.0 - initial release
// ============================================================================
package boreal_wload_pkg;

  localparam int unsigned N_COEF_DEF      = 16;
  localparam int unsigned ADDR_W_DEF      = 5;
  localparam int unsigned DATA_W_DEF      = 16;
  localparam logic [7:0]  SYNC_BYTE_DEF   = 8'hA5;
  localparam int unsigned TIMEOUT_CYC_DEF = 65535;
  localparam int unsigned TMO_W           = 16;

  localparam int unsigned ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_COUNT  = 3'd2,
    ST_DLO    = 3'd3,
    ST_DHI    = 3'd4,
    ST_CSUM   = 3'd5,
    ST_COMMIT = 3'd6
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_RANGE   = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // True while a frame is being received (the inter-byte timeout window).
  function automatic logic in_frame(input state_e s);
    return (s == ST_START) || (s == ST_COUNT) || (s == ST_DLO) ||
           (s == ST_DHI)   || (s == ST_CSUM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/boreal_weight_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : boreal_weight_loader_if
//  Purpose  : Bundles the host byte link and the filter coefficient port.
//  Signals  : in_data/in_valid/in_ready  - byte stream (valid/ready)
//             commit_ok                  - filter idle, write allowed
//             host_addr/host_din/host_we - coefficient write port
//             done/err/err_code          - frame status
//  Modports : master - host / filter side environment
//             slave  - the weight loader
//  Revision : 1.0 - initial release
// ============================================================================
interface boreal_weight_loader_if
  import boreal_wload_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              commit_ok;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_din;
  logic              host_we;
  logic              done;
  logic              err;
  logic [1:0]        err_code;

  modport master (
    output in_data, in_valid, commit_ok,
    input  in_ready, host_addr, host_din, host_we, done, err, err_code
  );

  modport slave (
    input  in_data, in_valid, commit_ok,
    output in_ready, host_addr, host_din, host_we, done, err, err_code
  );

endinterface
`default_nettype wire

// File: rtl/boreal_wload_shadow_ram.sv
`default_nettype none
// ============================================================================
//  Module   : boreal_wload_shadow_ram
//  Purpose  : DEPTH x WIDTH shadow buffer holding a frame until it has been
//             checksum-verified. One write port, one registered read port.
//  Ports    : clk, rst_n          - clock, async active-low reset
//             wr_en_i/wr_addr_i/wr_data_i - write port (frame parser)
//             rd_en_i/rd_addr_i   - read request (commit sequencer)
//             rd_data_o           - registered read data, holds when idle
//  Revision : 1.0 - initial release
// ============================================================================
module boreal_wload_shadow_ram
  import boreal_wload_pkg::*;
#(
  parameter int unsigned DEPTH = N_COEF_DEF,
  parameter int unsigned WIDTH = DATA_W_DEF,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             wr_en_i,
  input  wire logic [AW-1:0]    wr_addr_i,
  input  wire logic [WIDTH-1:0] wr_data_i,
  input  wire logic             rd_en_i,
  input  wire logic [AW-1:0]    rd_addr_i,
  output logic      [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage carries no reset: contents are meaningless until rewritten.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read data lands together with the write strobe it belongs to and holds
  // while the commit is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/boreal_weight_loader.sv
`default_nettype none
// ============================================================================
//  Module   : boreal_weight_loader
//  Purpose  : Receives a framed coefficient stream (SYNC, START, COUNT,
//             COUNT x {lo,hi}, CSUM) into a shadow buffer, verifies the XOR
//             checksum and only then replays the words onto the filter
//             coefficient port, one word per commit_ok cycle.
//  Ports    : clk    - system clock
//             rst_n  - asynchronous active-low reset
//             bus    - boreal_weight_loader_if.slave (byte link, filter
//                      port, done/err/err_code status)
//  Options  : BOREAL_WLOAD_TIMEOUT_EN - inter-byte timeout (err_code 3)
//  Revision : 1.0 - initial release
// ============================================================================
module boreal_weight_loader
  import boreal_wload_pkg::*;
#(
  parameter int unsigned N_COEF      = N_COEF_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input wire logic               clk,
  input wire logic               rst_n,
  boreal_weight_loader_if.slave  bus
);

  localparam int unsigned IDX_W = (N_COEF > 1) ? $clog2(N_COEF) : 1;
  localparam int unsigned CNT_W = $clog2(N_COEF + 1);

  state_e            state_q;
  logic              in_ready_q;
  logic [ADDR_W-1:0] host_addr_q;
  logic              host_we_q;
  logic              done_q;
  logic              err_q;
  logic [1:0]        err_code_q;
  logic [ADDR_W-1:0] start_q;
  logic              start_bad_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  k_q;
  logic [7:0]        lo_q;
  logic [7:0]        csum_q;

  logic [7:0]        csum_d;
  logic [CNT_W-1:0]  k_d;
  logic              w_fire;
  logic [8:0]        w_end;
  logic              w_range_bad;
  logic              w_ram_we;
  logic              w_ram_re;
  logic [DATA_W-1:0] w_rd_data;

  assign w_fire = bus.in_valid && in_ready_q;
  assign csum_d = csum_q ^ bus.in_data;
  assign k_d    = k_q + CNT_W'(1);

  // Frame must fit in the 2**ADDR_W coefficient space and in the buffer.
  assign w_end       = 9'(start_q) + 9'(bus.in_data);
  assign w_range_bad = (bus.in_data == 8'd0) || (bus.in_data > 8'(N_COEF)) ||
                       start_bad_q || (w_end > 9'(1 << ADDR_W));

  assign w_ram_we = w_fire && (state_q == ST_DHI);
  assign w_ram_re = (state_q == ST_COMMIT) && bus.commit_ok && (k_q != count_q);

  boreal_wload_shadow_ram #(
    .DEPTH (N_COEF),
    .WIDTH (DATA_W),
    .AW    (IDX_W)
  ) u_shadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (w_ram_we),
    .wr_addr_i (k_q[IDX_W-1:0]),
    .wr_data_i (DATA_W'({bus.in_data, lo_q})),
    .rd_en_i   (w_ram_re),
    .rd_addr_i (k_q[IDX_W-1:0]),
    .rd_data_o (w_rd_data)
  );

`ifdef BOREAL_WLOAD_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q;
  logic             w_tmo_hit;
  assign w_tmo_hit = in_frame(state_q) && !w_fire &&
                     (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      host_addr_q <= '0;
      host_we_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      start_q     <= '0;
      start_bad_q <= 1'b0;
      count_q     <= '0;
      k_q         <= '0;
      lo_q        <= '0;
      csum_q      <= '0;
`ifdef BOREAL_WLOAD_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      // Pulses default low; in_ready is dropped explicitly for COMMIT and
      // for the cycle in which err/done pulse.
      host_we_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b1;

`ifdef BOREAL_WLOAD_TIMEOUT_EN
      if (!in_frame(state_q) || w_fire) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TMO_W'(1);
      end
`endif

      case (state_q)
        ST_IDLE: begin
          if (w_fire && (bus.in_data == SYNC_BYTE)) begin
            csum_q  <= 8'h00;
            state_q <= ST_START;
          end
        end

        ST_START: begin
          if (w_fire) begin
            start_q     <= bus.in_data[ADDR_W-1:0];
            start_bad_q <= (bus.in_data >> ADDR_W) != 8'd0;
            csum_q      <= csum_d;
            state_q     <= ST_COUNT;
          end
        end

        ST_COUNT: begin
          if (w_fire) begin
            csum_q  <= csum_d;
            count_q <= bus.in_data[CNT_W-1:0];
            k_q     <= '0;
            if (w_range_bad) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_RANGE;
              in_ready_q <= 1'b0;
              state_q    <= ST_IDLE;
            end else begin
              state_q    <= ST_DLO;
            end
          end
        end

        ST_DLO: begin
          if (w_fire) begin
            lo_q    <= bus.in_data;
            csum_q  <= csum_d;
            state_q <= ST_DHI;
          end
        end

        ST_DHI: begin
          // Shadow write happens combinationally on this transfer.
          if (w_fire) begin
            csum_q  <= csum_d;
            k_q     <= k_d;
            state_q <= (k_d == count_q) ? ST_CSUM : ST_DLO;
          end
        end

        ST_CSUM: begin
          if (w_fire) begin
            in_ready_q <= 1'b0;
            if (bus.in_data == csum_q) begin
              k_q     <= '0;
              state_q <= ST_COMMIT;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ERR_CSUM;
              state_q    <= ST_IDLE;
            end
          end
        end

        ST_COMMIT: begin
          in_ready_q <= 1'b0;
          if (k_q == count_q) begin
            // Last strobe was issued on the previous edge.
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else if (bus.commit_ok) begin
            host_we_q   <= 1'b1;
            host_addr_q <= start_q + ADDR_W'(k_q);
            k_q         <= k_d;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase

`ifdef BOREAL_WLOAD_TIMEOUT_EN
      if (w_tmo_hit) begin
        err_q      <= 1'b1;
        err_code_q <= ERR_TIMEOUT;
        in_ready_q <= 1'b0;
        state_q    <= ST_IDLE;
      end
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.host_addr = host_addr_q;
  assign bus.host_din  = w_rd_data;
  assign bus.host_we   = host_we_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;

endmodule
`default_nettype wire
